control_fsm: RTL

Clocked multi-cycle control sequencer for the 16-bit accumulator CPU. It replaces the level-triggered, delay-driven control decoder with a synchronous FSM: FETCH / DECODE / EXEC / HOLD / HALT. It adds a memory-ready handshake, a parametrised opcode width and post-jump hold length, and two new conditional jumps. It sits between the instruction register and the ALU, accumulator, data memory and program counter.

---
 rtl/control_fsm.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/control_fsm.sv
// Multi-cycle control sequencer for the 16-bit accumulator CPU (IDLE/FETCH/DECODE/EXEC/HOLD/HALT).
// Define CU_ILLEGAL_TRAP_EN to trap illegal opcodes into HALT instead of treating them as NOP.
module control_fsm #(
  parameter int OPCODE_W  = 5,
  parameter int JUMP_HOLD = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zr,
  input  logic                ng,
  input  logic                mem_ready,
  output logic                zx,
  output logic                nx,
  output logic                zy,
  output logic                ny,
  output logic                f,
  output logic                no,
  output logic                load_acc,
  output logic                load_mem,
  output logic                ir_load,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                pc_hold,
  output logic                halted,
  output logic                illegal
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [4:0] OP_LDA  = 5'h12;
  localparam logic [4:0] OP_STA  = 5'h13;
  localparam logic [4:0] OP_JMP  = 5'h14;
  localparam logic [4:0] OP_JZ   = 5'h15;
  localparam logic [4:0] OP_JN   = 5'h16;
  localparam logic [4:0] OP_HALT = 5'h17;
  localparam logic [4:0] OP_JNZ  = 5'h18;
  localparam logic [4:0] OP_JP   = 5'h19;
  localparam logic [4:0] OP_NOP  = 5'h1A;

  localparam logic [3:0] HOLD_LEN = 4'(JUMP_HOLD);
  localparam logic       HOLD_EN  = (JUMP_HOLD != 0);

  logic [2:0]          state_r;
  logic [2:0]          next_state_s;
  logic [OPCODE_W-1:0] op_r;
  logic                zr_r;
  logic                ng_r;
  logic [3:0]          hold_cnt_r;
  logic [4:0]          op_low_s;
  logic                upper_nz_s;
  logic                illegal_op_s;
  logic                jump_taken_s;
  logic [5:0]          alu_s;

  // ALU control word (zx nx zy ny f no) for the ALU opcodes and LDA.
  function automatic logic [5:0] alu_ctrl(input logic [4:0] op);
    logic [5:0] c;
    case (op)
      5'h00:   c = 6'b101010;
      5'h01:   c = 6'b111111;
      5'h02:   c = 6'b111010;
      5'h03:   c = 6'b001100;
      5'h04:   c = 6'b110001;
      5'h05:   c = 6'b001101;
      5'h06:   c = 6'b100001;
      5'h07:   c = 6'b001111;
      5'h08:   c = 6'b110011;
      5'h09:   c = 6'b011111;
      5'h0A:   c = 6'b110111;
      5'h0B:   c = 6'b001110;
      5'h0C:   c = 6'b110010;
      5'h0D:   c = 6'b000010;
      5'h0E:   c = 6'b010011;
      5'h0F:   c = 6'b000111;
      5'h10:   c = 6'b000000;
      5'h11:   c = 6'b010101;
      5'h12:   c = 6'b110000;
      default: c = 6'b000000;
    endcase
    return c;
  endfunction

  generate
    if (OPCODE_W > 5) begin : g_upper
      assign upper_nz_s = |op_r[OPCODE_W-1:5];
    end else begin : g_no_upper
      assign upper_nz_s = 1'b0;
    end
  endgenerate

  assign op_low_s     = op_r[4:0];
  assign illegal_op_s = upper_nz_s | (op_low_s > OP_NOP);
  assign alu_s        = alu_ctrl(op_low_s);

  // Jump condition evaluated on the flags captured in DECODE, never the live ones.
  always_comb begin
    jump_taken_s = 1'b0;
    case (op_low_s)
      OP_JMP:  jump_taken_s = 1'b1;
      OP_JZ:   jump_taken_s = zr_r;
      OP_JN:   jump_taken_s = ng_r;
      OP_JNZ:  jump_taken_s = ~zr_r;
      OP_JP:   jump_taken_s = ~zr_r & ~ng_r;
      default: jump_taken_s = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: next_state_s = S_FETCH;
      S_FETCH: begin
        if (mem_ready) next_state_s = S_DECODE;
        else           next_state_s = S_FETCH;
      end
      S_DECODE: next_state_s = S_EXEC;
      S_EXEC: begin
        if (illegal_op_s) begin
`ifdef CU_ILLEGAL_TRAP_EN
          next_state_s = S_HALT;
`else
          next_state_s = S_FETCH;
`endif
        end else if (op_low_s == OP_STA) begin
          if (mem_ready) next_state_s = S_FETCH;
          else           next_state_s = S_EXEC;
        end else if (op_low_s == OP_HALT) begin
          next_state_s = S_HALT;
        end else if (jump_taken_s && HOLD_EN) begin
          next_state_s = S_HOLD;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_HOLD: begin
        if (hold_cnt_r == 4'd0) next_state_s = S_FETCH;
        else                    next_state_s = S_HOLD;
      end
      S_HALT:  next_state_s = S_HALT;
      default: next_state_s = S_IDLE;
    endcase
  end

  // State, latched opcode/flags and post-jump hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      op_r       <= '0;
      zr_r       <= 1'b0;
      ng_r       <= 1'b0;
      hold_cnt_r <= 4'd0;
    end else begin
      state_r <= next_state_s;
      if (state_r == S_DECODE) begin
        op_r <= opcode;
        zr_r <= zr;
        ng_r <= ng;
      end else begin
        op_r <= op_r;
        zr_r <= zr_r;
        ng_r <= ng_r;
      end
      // Loaded with length-1 so HOLD lasts exactly JUMP_HOLD cycles.
      if ((state_r == S_EXEC) && (next_state_s == S_HOLD)) begin
        hold_cnt_r <= HOLD_LEN - 4'd1;
      end else if ((state_r == S_HOLD) && (hold_cnt_r != 4'd0)) begin
        hold_cnt_r <= hold_cnt_r - 4'd1;
      end else begin
        hold_cnt_r <= 4'd0;
      end
    end
  end

  // Moore output decode of state and op_r; only ir_load and STA pc_inc see mem_ready.
  always_comb begin
    {zx, nx, zy, ny, f, no} = 6'b000000;
    load_acc = 1'b0;
    load_mem = 1'b0;
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    pc_hold  = 1'b0;
    halted   = 1'b0;
    illegal  = 1'b0;
    case (state_r)
      S_FETCH: ir_load = mem_ready;
      S_EXEC: begin
        if (illegal_op_s) begin
          illegal = 1'b1;
`ifdef CU_ILLEGAL_TRAP_EN
          pc_inc = 1'b0;
`else
          pc_inc = 1'b1;
`endif
        end else if (op_low_s <= OP_LDA) begin
          {zx, nx, zy, ny, f, no} = alu_s;
          load_acc = 1'b1;
          pc_inc   = 1'b1;
        end else if (op_low_s == OP_STA) begin
          load_mem = 1'b1;
          pc_inc   = mem_ready;
        end else if (op_low_s == OP_HALT) begin
          pc_inc = 1'b0;
        end else if (op_low_s == OP_NOP) begin
          pc_inc = 1'b1;
        end else if (jump_taken_s) begin
          pc_load = 1'b1;
        end else begin
          pc_inc = 1'b1;
        end
      end
      S_HOLD: pc_hold = 1'b1;
      S_HALT: begin
        halted = 1'b1;
`ifdef CU_ILLEGAL_TRAP_EN
        illegal = illegal_op_s;
`else
        illegal = 1'b0;
`endif
      end
      default: ir_load = 1'b0;
    endcase
  end

endmodule
